multcyc_ctrl_fsm: RTL and testbench

Multi-cycle successor to the single-cycle control unit. It drives a shared-ALU, single-memory MIPS datapath through a Moore state machine, one instruction over 3-5+ cycles. Memory accesses use a ready handshake with a configurable timeout. The block sits beside the datapath inside multcyc_core and also keeps a retired-instruction counter.

---
 rtl/multcyc_pkg.sv | 96 +++++++++
 rtl/multcyc_opdecode.sv | 39 +++
 rtl/multcyc_ctrl_fsm.sv | 231 +++++++++++++++++++++++
 tb/tb_multcyc_ctrl_fsm.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multcyc_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control unit.
// State numbering is fixed because oState is exposed for debug.
package multcyc_pkg;

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_MEMADR = 4'd2,
    ST_MEMRD  = 4'd3,
    ST_MEMWB  = 4'd4,
    ST_MEMWR  = 4'd5,
    ST_REXEC  = 4'd6,
    ST_RWB    = 4'd7,
    ST_BRANCH = 4'd8,
    ST_JUMP   = 4'd9,
    ST_IEXEC  = 4'd10,
    ST_IWB    = 4'd11,
    ST_JREG   = 4'd12,
    ST_TRAP   = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2a;
  localparam logic [5:0] FN_SLTU = 6'h2b;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MDR = 2'b01;
  localparam logic [1:0] M2R_PC  = 2'b10;

  localparam logic [1:0] SRCB_REGB  = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_OPC   = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REGA   = 2'b11;

  localparam logic [31:0] EXC_VECTOR = 32'h8000_0004;

  typedef struct packed {
    logic mem;
    logic rtype;
    logic jreg;
    logic branch;
    logic jump;
    logic link;
    logic itype;
    logic illegal;
  } iclass_t;

  function automatic logic fn_is_legal(input logic [5:0] fn);
    case (fn)
      FN_SLL, FN_SRL, FN_SRA, FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
      FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU: fn_is_legal = 1'b1;
      default:                                        fn_is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multcyc_opdecode.sv
// Combinational opcode/funct classifier feeding DECODE next-state selection.
// With MULTCYC_TRAP_EN, unknown R-type functs are flagged illegal instead of executed.
module multcyc_opdecode
  import multcyc_pkg::*;
(
  input  logic [5:0] iOpCode,
  input  logic [5:0] iFunct,
  output iclass_t    oClass
);

  always_comb begin
    oClass = '0;
    case (iOpCode)
      OP_LW, OP_SW: oClass.mem = 1'b1;
      OP_RTYPE: begin
        if (iFunct == FN_JR || iFunct == FN_JALR) begin
          oClass.jreg = 1'b1;
          oClass.link = (iFunct == FN_JALR);
        end else begin
`ifdef MULTCYC_TRAP_EN
          oClass.rtype   = fn_is_legal(iFunct);
          oClass.illegal = ~fn_is_legal(iFunct);
`else
          oClass.rtype = 1'b1;
`endif
        end
      end
      OP_BEQ, OP_BNE: oClass.branch = 1'b1;
      OP_J:           oClass.jump   = 1'b1;
      OP_JAL: begin
        oClass.jump = 1'b1;
        oClass.link = 1'b1;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_LUI: oClass.itype = 1'b1;
      default: oClass.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multcyc_ctrl_fsm.sv
// Moore control FSM for the shared-ALU multi-cycle MIPS datapath, with memory
// ready timeout and retire counter. Optional trap state: define MULTCYC_TRAP_EN.
module multcyc_ctrl_fsm
  import multcyc_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_WIDTH   = 32,
  parameter int TIMER_WIDTH = 8
) (
  input  logic                 iClk,
  input  logic                 iRst_n,
  input  logic [5:0]           iOpCode,
  input  logic [5:0]           iFunct,
  input  logic                 iMemReady,
  output logic                 oPCWrite,
  output logic                 oPCWriteCond,
  output logic                 oBranchEq,
  output logic                 oIorD,
  output logic                 oIRWrite,
  output logic                 oMemRead,
  output logic                 oMemWrite,
  output logic                 oRegWrite,
  output logic [1:0]           oRegDst,
  output logic [1:0]           oMemtoReg,
  output logic                 oALUSrcA,
  output logic [1:0]           oALUSrcB,
  output logic [1:0]           oALUOp,
  output logic [1:0]           oPCSource,
  output logic                 oMemErr,
  output logic                 oRetire,
  output logic [CNT_WIDTH-1:0] oInstCount,
  output logic [3:0]           oState
`ifdef MULTCYC_TRAP_EN
  ,
  output logic                 oTrap
`endif
);

  localparam logic [TIMER_WIDTH-1:0] TO_LAST =
    (MEM_TIMEOUT > 0) ? TIMER_WIDTH'(MEM_TIMEOUT - 1) : '0;

  state_t                 r_state;
  state_t                 w_next;
  logic [TIMER_WIDTH-1:0] r_wait;
  logic [CNT_WIDTH-1:0]   r_count;
  iclass_t                w_class;
  logic                   w_ready;
  logic                   w_memstate;
  logic                   w_timeout;

  multcyc_opdecode u_opdecode (
    .iOpCode (iOpCode),
    .iFunct  (iFunct),
    .oClass  (w_class)
  );

  // Ready is masked during reset so no strobe can fire in the reset cycle.
  assign w_ready    = iMemReady & iRst_n;
  assign w_memstate = (r_state == ST_FETCH) || (r_state == ST_MEMRD) || (r_state == ST_MEMWR);
  assign w_timeout  = (MEM_TIMEOUT > 0) && iRst_n && w_memstate && !w_ready
                      && (r_wait == TO_LAST);

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) r_state <= ST_FETCH;
    else         r_state <= w_next;
  end

  // A FETCH timeout stays in FETCH, so clear on timeout as well as on state change.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n)                               r_wait <= '0;
    else if (w_next != r_state || w_timeout)   r_wait <= '0;
    else if (w_memstate && !w_ready)           r_wait <= r_wait + 1'b1;
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n)      r_count <= '0;
    else if (oRetire) r_count <= r_count + 1'b1;
  end

  always_comb begin
    w_next       = r_state;
    oPCWrite     = 1'b0;
    oPCWriteCond = 1'b0;
    oBranchEq    = 1'b0;
    oIorD        = 1'b0;
    oIRWrite     = 1'b0;
    oMemRead     = 1'b0;
    oMemWrite    = 1'b0;
    oRegWrite    = 1'b0;
    oRegDst      = REGDST_RT;
    oMemtoReg    = M2R_ALU;
    oALUSrcA     = 1'b0;
    oALUSrcB     = SRCB_REGB;
    oALUOp       = ALUOP_ADD;
    oPCSource    = PCSRC_ALU;
    oMemErr      = w_timeout;
    oRetire      = 1'b0;
`ifdef MULTCYC_TRAP_EN
    oTrap        = 1'b0;
`endif
    case (r_state)
      ST_FETCH: begin
        oMemRead = 1'b1;
        oALUSrcB = SRCB_FOUR;
        if (w_timeout) begin
          w_next = ST_FETCH;
        end else if (w_ready) begin
          oIRWrite = 1'b1;
          oPCWrite = 1'b1;
          w_next   = ST_DECODE;
        end
      end
      ST_DECODE: begin
        oALUSrcB = SRCB_IMMSH;
        if (w_class.mem)         w_next = ST_MEMADR;
        else if (w_class.jreg)   w_next = ST_JREG;
        else if (w_class.rtype)  w_next = ST_REXEC;
        else if (w_class.branch) w_next = ST_BRANCH;
        else if (w_class.jump)   w_next = ST_JUMP;
        else if (w_class.itype)  w_next = ST_IEXEC;
        else if (w_class.illegal) begin
`ifdef MULTCYC_TRAP_EN
          w_next = ST_TRAP;
`else
          w_next = ST_FETCH;
`endif
        end else                 w_next = ST_FETCH;
      end
      ST_MEMADR: begin
        oALUSrcA = 1'b1;
        oALUSrcB = SRCB_IMM;
        w_next   = (iOpCode == OP_SW) ? ST_MEMWR : ST_MEMRD;
      end
      ST_MEMRD: begin
        oIorD    = 1'b1;
        oMemRead = 1'b1;
        if (w_timeout)    w_next = ST_FETCH;
        else if (w_ready) w_next = ST_MEMWB;
      end
      ST_MEMWB: begin
        oRegDst   = REGDST_RT;
        oMemtoReg = M2R_MDR;
        oRegWrite = 1'b1;
        oRetire   = 1'b1;
        w_next    = ST_FETCH;
      end
      ST_MEMWR: begin
        oIorD     = 1'b1;
        oMemWrite = 1'b1;
        if (w_timeout) begin
          w_next = ST_FETCH;
        end else if (w_ready) begin
          oRetire = 1'b1;
          w_next  = ST_FETCH;
        end
      end
      ST_REXEC: begin
        oALUSrcA = 1'b1;
        oALUSrcB = SRCB_REGB;
        oALUOp   = ALUOP_FUNCT;
        w_next   = ST_RWB;
      end
      ST_RWB: begin
        oRegDst   = REGDST_RD;
        oMemtoReg = M2R_ALU;
        oRegWrite = 1'b1;
        oRetire   = 1'b1;
        w_next    = ST_FETCH;
      end
      ST_IEXEC: begin
        oALUSrcA = 1'b1;
        oALUSrcB = SRCB_IMM;
        oALUOp   = ALUOP_OPC;
        w_next   = ST_IWB;
      end
      ST_IWB: begin
        oRegDst   = REGDST_RT;
        oMemtoReg = M2R_ALU;
        oRegWrite = 1'b1;
        oRetire   = 1'b1;
        w_next    = ST_FETCH;
      end
      ST_BRANCH: begin
        oALUSrcA     = 1'b1;
        oALUSrcB     = SRCB_REGB;
        oALUOp       = ALUOP_SUB;
        oPCWriteCond = 1'b1;
        oPCSource    = PCSRC_ALUOUT;
        oBranchEq    = (iOpCode == OP_BEQ);
        oRetire      = 1'b1;
        w_next       = ST_FETCH;
      end
      // PC already holds PC+4 here, which is the link value for jal.
      ST_JUMP: begin
        oPCWrite  = 1'b1;
        oPCSource = PCSRC_JUMP;
        oRetire   = 1'b1;
        if (w_class.link) begin
          oRegWrite = 1'b1;
          oRegDst   = REGDST_RA;
          oMemtoReg = M2R_PC;
        end
        w_next = ST_FETCH;
      end
      ST_JREG: begin
        oPCWrite  = 1'b1;
        oPCSource = PCSRC_REGA;
        oRetire   = 1'b1;
        if (w_class.link) begin
          oRegWrite = 1'b1;
          oRegDst   = REGDST_RD;
          oMemtoReg = M2R_PC;
        end
        w_next = ST_FETCH;
      end
      ST_TRAP: begin
`ifdef MULTCYC_TRAP_EN
        oPCWrite  = 1'b1;
        oPCSource = PCSRC_JUMP;
        oTrap     = 1'b1;
`endif
        w_next = ST_FETCH;
      end
      default: w_next = ST_FETCH;
    endcase
  end

  assign oInstCount = r_count;
  assign oState     = r_state;

endmodule

// File: tb/tb_multcyc_ctrl_fsm.sv
// Directed self-checking bench for multcyc_ctrl_fsm (MEM_TIMEOUT=4, 3-bit counter).
// Honours MULTCYC_TRAP_EN for the illegal-opcode step.
module tb_multcyc_ctrl_fsm;

  localparam int CW = 3;

  logic          iClk = 1'b0;
  logic          iRst_n;
  logic [5:0]    iOpCode;
  logic [5:0]    iFunct;
  logic          iMemReady;
  logic          oPCWrite, oPCWriteCond, oBranchEq, oIorD, oIRWrite;
  logic          oMemRead, oMemWrite, oRegWrite, oALUSrcA, oMemErr, oRetire;
  logic [1:0]    oRegDst, oMemtoReg, oALUSrcB, oALUOp, oPCSource;
  logic [CW-1:0] oInstCount;
  logic [3:0]    oState;
`ifdef MULTCYC_TRAP_EN
  logic          oTrap;
`endif

  int checks  = 0;
  int errors  = 0;
  int exp_cnt = 0;

  multcyc_ctrl_fsm #(
    .MEM_TIMEOUT (4),
    .CNT_WIDTH   (CW),
    .TIMER_WIDTH (8)
  ) dut (
    .iClk         (iClk),
    .iRst_n       (iRst_n),
    .iOpCode      (iOpCode),
    .iFunct       (iFunct),
    .iMemReady    (iMemReady),
    .oPCWrite     (oPCWrite),
    .oPCWriteCond (oPCWriteCond),
    .oBranchEq    (oBranchEq),
    .oIorD        (oIorD),
    .oIRWrite     (oIRWrite),
    .oMemRead     (oMemRead),
    .oMemWrite    (oMemWrite),
    .oRegWrite    (oRegWrite),
    .oRegDst      (oRegDst),
    .oMemtoReg    (oMemtoReg),
    .oALUSrcA     (oALUSrcA),
    .oALUSrcB     (oALUSrcB),
    .oALUOp       (oALUOp),
    .oPCSource    (oPCSource),
    .oMemErr      (oMemErr),
    .oRetire      (oRetire),
    .oInstCount   (oInstCount),
    .oState       (oState)
`ifdef MULTCYC_TRAP_EN
    ,
    .oTrap        (oTrap)
`endif
  );

  always #5 iClk = ~iClk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge iClk);
    #2;
  endtask

  task automatic drv(input logic [5:0] op, input logic [5:0] fn, input logic rdy);
    iOpCode   = op;
    iFunct    = fn;
    iMemReady = rdy;
    #1;
  endtask

  task automatic chk_cnt(input string tag);
    chk(tag, 32'(oInstCount), 32'(exp_cnt & ((1 << CW) - 1)));
  endtask

  // FETCH with ready high, then DECODE; leaves the bench at the first execute cycle.
  task automatic fetch_decode(input logic [5:0] op, input logic [5:0] fn);
    drv(op, fn, 1'b1);
    chk("fetch_state", 32'(oState), 32'd0);
    chk("fetch_irwrite", 32'(oIRWrite), 32'd1);
    chk("fetch_pcwrite", 32'(oPCWrite), 32'd1);
    chk("fetch_srcb", 32'(oALUSrcB), 32'd1);
    nxt();
    drv(op, fn, 1'b0);
    chk("decode_state", 32'(oState), 32'd1);
    chk("decode_srcb", 32'(oALUSrcB), 32'd3);
    nxt();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    iRst_n = 1'b0;
    drv(6'h00, 6'h00, 1'b0);
    repeat (2) nxt();
    chk("rst_state", 32'(oState), 32'd0);
    chk("rst_count", 32'(oInstCount), 32'd0);
    chk("rst_memread", 32'(oMemRead), 32'd1);
    chk("rst_pcwrite", 32'(oPCWrite), 32'd0);
    iRst_n = 1'b1;

    // add: 0,1,6,7,0
    fetch_decode(6'h00, 6'h20);
    drv(6'h00, 6'h20, 1'b0);
    chk("rexec_state", 32'(oState), 32'd6);
    chk("rexec_aluop", 32'(oALUOp), 32'd2);
    chk("rexec_srca", 32'(oALUSrcA), 32'd1);
    nxt();
    chk("rwb_state", 32'(oState), 32'd7);
    chk("rwb_regwrite", 32'(oRegWrite), 32'd1);
    chk("rwb_regdst", 32'(oRegDst), 32'd1);
    chk("rwb_retire", 32'(oRetire), 32'd1);
    chk_cnt("rwb_count");
    exp_cnt++;
    nxt();
    chk("add_done_state", 32'(oState), 32'd0);
    chk_cnt("add_count");

    // lw with three not-ready cycles in MEMRD
    fetch_decode(6'h23, 6'h00);
    chk("memadr_state", 32'(oState), 32'd2);
    chk("memadr_srcb", 32'(oALUSrcB), 32'd2);
    nxt();
    for (int i = 0; i < 4; i++) begin
      drv(6'h23, 6'h00, (i == 3));
      chk("memrd_state", 32'(oState), 32'd3);
      chk("memrd_iord", 32'(oIorD), 32'd1);
      chk("memrd_memread", 32'(oMemRead), 32'd1);
      chk("memrd_memerr", 32'(oMemErr), 32'd0);
      nxt();
    end
    drv(6'h23, 6'h00, 1'b0);
    chk("memwb_state", 32'(oState), 32'd4);
    chk("memwb_regwrite", 32'(oRegWrite), 32'd1);
    chk("memwb_memtoreg", 32'(oMemtoReg), 32'd1);
    chk("memwb_retire", 32'(oRetire), 32'd1);
    exp_cnt++;
    nxt();
    chk_cnt("lw_count");

    // sw that never gets ready: timeout on the 4th MEMWR cycle
    fetch_decode(6'h2b, 6'h00);
    chk("sw_memadr_state", 32'(oState), 32'd2);
    nxt();
    for (int i = 0; i < 4; i++) begin
      drv(6'h2b, 6'h00, 1'b0);
      chk("memwr_state", 32'(oState), 32'd5);
      chk("memwr_memwrite", 32'(oMemWrite), 32'd1);
      chk("memwr_memerr", 32'(oMemErr), 32'(i == 3));
      chk("memwr_retire", 32'(oRetire), 32'd0);
      nxt();
    end
    chk("sw_to_state", 32'(oState), 32'd0);
    chk_cnt("sw_to_count");

    // FETCH timeout then counter restarts from zero
    for (int i = 0; i < 5; i++) begin
      drv(6'h00, 6'h20, 1'b0);
      chk("fetchto_state", 32'(oState), 32'd0);
      chk("fetchto_memerr", 32'(oMemErr), 32'(i == 3));
      chk("fetchto_irwrite", 32'(oIRWrite), 32'd0);
      nxt();
    end

    // jal
    fetch_decode(6'h03, 6'h00);
    chk("jal_state", 32'(oState), 32'd9);
    chk("jal_pcwrite", 32'(oPCWrite), 32'd1);
    chk("jal_pcsource", 32'(oPCSource), 32'd2);
    chk("jal_regwrite", 32'(oRegWrite), 32'd1);
    chk("jal_regdst", 32'(oRegDst), 32'd2);
    chk("jal_memtoreg", 32'(oMemtoReg), 32'd2);
    chk("jal_retire", 32'(oRetire), 32'd1);
    exp_cnt++;
    nxt();

    // bne then beq
    fetch_decode(6'h05, 6'h00);
    chk("bne_state", 32'(oState), 32'd8);
    chk("bne_pcwcond", 32'(oPCWriteCond), 32'd1);
    chk("bne_brancheq", 32'(oBranchEq), 32'd0);
    chk("bne_aluop", 32'(oALUOp), 32'd1);
    chk("bne_pcsource", 32'(oPCSource), 32'd1);
    chk("bne_pcwrite", 32'(oPCWrite), 32'd0);
    exp_cnt++;
    nxt();
    fetch_decode(6'h04, 6'h00);
    chk("beq_state", 32'(oState), 32'd8);
    chk("beq_brancheq", 32'(oBranchEq), 32'd1);
    exp_cnt++;
    nxt();

    // jr then jalr
    fetch_decode(6'h00, 6'h08);
    chk("jr_state", 32'(oState), 32'd12);
    chk("jr_pcsource", 32'(oPCSource), 32'd3);
    chk("jr_pcwrite", 32'(oPCWrite), 32'd1);
    chk("jr_regwrite", 32'(oRegWrite), 32'd0);
    exp_cnt++;
    nxt();
    fetch_decode(6'h00, 6'h09);
    chk("jalr_state", 32'(oState), 32'd12);
    chk("jalr_regwrite", 32'(oRegWrite), 32'd1);
    chk("jalr_regdst", 32'(oRegDst), 32'd1);
    chk("jalr_memtoreg", 32'(oMemtoReg), 32'd2);
    exp_cnt++;
    nxt();
    chk_cnt("pre_wrap_count");

    // addi: 8th retire wraps the 3-bit counter
    fetch_decode(6'h08, 6'h00);
    chk("iexec_state", 32'(oState), 32'd10);
    chk("iexec_aluop", 32'(oALUOp), 32'd3);
    chk("iexec_srcb", 32'(oALUSrcB), 32'd2);
    nxt();
    chk("iwb_state", 32'(oState), 32'd11);
    chk("iwb_regwrite", 32'(oRegWrite), 32'd1);
    chk("iwb_regdst", 32'(oRegDst), 32'd0);
    exp_cnt++;
    nxt();
    chk_cnt("wrap_count");

    // undefined opcode
    fetch_decode(6'h3f, 6'h00);
`ifdef MULTCYC_TRAP_EN
    chk("trap_state", 32'(oState), 32'd13);
    chk("trap_pulse", 32'(oTrap), 32'd1);
    chk("trap_pcwrite", 32'(oPCWrite), 32'd1);
    chk("trap_pcsource", 32'(oPCSource), 32'd2);
    chk("trap_retire", 32'(oRetire), 32'd0);
    nxt();
    chk("trap_exit_state", 32'(oState), 32'd0);
    chk("trap_exit_pulse", 32'(oTrap), 32'd0);
`else
    chk("illegal_state", 32'(oState), 32'd0);
    chk("illegal_regwrite", 32'(oRegWrite), 32'd0);
    chk("illegal_memwrite", 32'(oMemWrite), 32'd0);
`endif
    chk_cnt("illegal_count");

    // reset asserted while MEMWR is waiting
    fetch_decode(6'h2b, 6'h00);
    nxt();
    drv(6'h2b, 6'h00, 1'b0);
    chk("prerst_state", 32'(oState), 32'd5);
    nxt();
    drv(6'h2b, 6'h00, 1'b1);
    iRst_n = 1'b0;
    #1;
    exp_cnt = 0;
    chk("midrst_state", 32'(oState), 32'd0);
    chk("midrst_memwrite", 32'(oMemWrite), 32'd0);
    chk("midrst_pcwrite", 32'(oPCWrite), 32'd0);
    chk("midrst_irwrite", 32'(oIRWrite), 32'd0);
    chk("midrst_regwrite", 32'(oRegWrite), 32'd0);
    chk("midrst_retire", 32'(oRetire), 32'd0);
    chk_cnt("midrst_count");
    nxt();
    iRst_n = 1'b1;
    drv(6'h00, 6'h20, 1'b0);
    chk("postrst_state", 32'(oState), 32'd0);
    chk("postrst_memread", 32'(oMemRead), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
